ccip_c0_rd_arbiter: RTL and testbench

- Shares the CCI-P channel-0 read-request path between N_REQ user requesters inside the AFU.
- Sits between the user AFU logic and the registered CCI-P Tx/Rx ports.
- Round-robin arbitration, gated by c0 almost-full and a per-requester outstanding-read limit.
- Tags each request's mdata with the requester ID and routes read responses back by that tag.
- Drain FSM quiesces traffic before soft reconfiguration.

---
 rtl/ccip_c0_rd_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ccip_c0_rd_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_c0_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read-request path between N_REQ requesters,
// with per-requester outstanding-read limits, mdata ID tagging, response routing and a drain FSM.
module ccip_c0_rd_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 42,
  parameter int UMDATA_W = 12,
  parameter int MAX_OUT  = 32
) (
  input  logic                         pClk,
  input  logic                         pck_cp2af_softReset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*ADDR_W-1:0]      req_addr,
  input  logic [N_REQ*UMDATA_W-1:0]    req_mdata,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         c0_tx_valid,
  output logic [ADDR_W-1:0]            c0_tx_addr,
  output logic [15:0]                  c0_tx_mdata,
  input  logic                         c0_tx_almfull,
  input  logic                         c0_rx_valid,
  input  logic [15:0]                  c0_rx_mdata,
  input  logic [511:0]                 c0_rx_data,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [UMDATA_W-1:0]          rsp_mdata,
  output logic [511:0]                 rsp_data,
  input  logic                         drain_req,
  output logic                         drained,
  output logic                         err_sticky,
  output logic [1:0]                   dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUT) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  // dbg_state encoding: 0 = RUN, 1 = DRAIN, 2 = IDLE
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_IDLE  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [IDX_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_out_cnt [N_REQ];

  logic                r_tx_valid;
  logic [ADDR_W-1:0]   r_tx_addr;
  logic [15:0]         r_tx_mdata;
  logic [N_REQ-1:0]    r_rsp_valid;
  logic [UMDATA_W-1:0] r_rsp_mdata;
  logic [511:0]        r_rsp_data;
  logic                r_err;

  logic                w_grant_en;
  logic                w_drained;
  logic [N_REQ-1:0]    w_elig;
  logic                w_gnt;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic [IDX_W-1:0]    w_cand;
  logic [N_REQ-1:0]    w_ready;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [UMDATA_W-1:0] w_sel_umdata;
  logic [3:0]          w_rx_id;
  logic                w_rx_id_ok;
  logic [N_REQ-1:0]    w_rx_onehot;
  logic                w_uflow;
  logic [N_REQ-1:0]    w_inc;
  logic [N_REQ-1:0]    w_dec;
  logic                w_cnt_all_zero;

  // Handshake: a request from requester i is accepted in a cycle where req_valid[i] && req_ready[i];
  // req_ready is a combinational one-hot grant that never depends on the requester's own ready.

  assign w_rx_id    = c0_rx_mdata[15:12];
  assign w_rx_id_ok = (int'(w_rx_id) < N_REQ);

  always_comb begin
    w_elig         = '0;
    w_rx_onehot    = '0;
    w_uflow        = 1'b0;
    w_cnt_all_zero = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i]      = req_valid[i] && (r_out_cnt[i] < MAX_CNT);
      w_rx_onehot[i] = c0_rx_valid && w_rx_id_ok && (w_rx_id == 4'(i));
      if (w_rx_onehot[i] && (r_out_cnt[i] == '0)) w_uflow = 1'b1;
      if (r_out_cnt[i] != '0) w_cnt_all_zero = 1'b0;
    end
  end

  // Round-robin search starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_gnt && w_elig[w_cand]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (!w_grant_en) w_gnt = 1'b0;
  end

  always_comb begin
    w_ready      = '0;
    w_sel_addr   = '0;
    w_sel_umdata = '0;
    w_inc        = '0;
    w_dec        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == IDX_W'(i)) begin
        w_ready[i]   = w_gnt;
        w_inc[i]     = w_gnt;
        w_sel_addr   = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_umdata = req_mdata[i*UMDATA_W +: UMDATA_W];
      end
      // An underflow response is routed but must not wrap the counter.
      w_dec[i] = w_rx_onehot[i] && (r_out_cnt[i] != '0);
    end
  end

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (drain_req) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!drain_req)                          w_state_nxt = S_RUN;
        else if (w_cnt_all_zero && !r_tx_valid)  w_state_nxt = S_IDLE;
      end
      S_IDLE:  if (!drain_req) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // drain_req blocks grants in the same cycle it is seen in RUN.
  always_comb begin
    w_grant_en = (r_state == S_RUN) && !drain_req && !c0_tx_almfull;
    w_drained  = (r_state == S_IDLE);
  end

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      r_ptr      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_addr  <= '0;
      r_tx_mdata <= '0;
      for (int i = 0; i < N_REQ; i++) r_out_cnt[i] <= '0;
    end else begin
      r_tx_valid <= w_gnt;
      if (w_gnt) begin
        r_ptr      <= (w_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        r_tx_addr  <= w_sel_addr;
        r_tx_mdata <= {4'(w_gnt_idx), 12'(w_sel_umdata)};
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (w_inc[i] && !w_dec[i])      r_out_cnt[i] <= r_out_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i]) r_out_cnt[i] <= r_out_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      r_rsp_valid <= '0;
      r_rsp_mdata <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_rx_onehot;
      if (c0_rx_valid && w_rx_id_ok) begin
        r_rsp_mdata <= c0_rx_mdata[UMDATA_W-1:0];
        r_rsp_data  <= c0_rx_data;
      end
      if (c0_rx_valid && (!w_rx_id_ok || w_uflow)) r_err <= 1'b1;
    end
  end

  assign req_ready   = w_ready;
  assign c0_tx_valid = r_tx_valid;
  assign c0_tx_addr  = r_tx_addr;
  assign c0_tx_mdata = r_tx_mdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_mdata   = r_rsp_mdata;
  assign rsp_data    = r_rsp_data;
  assign drained     = w_drained;
  assign err_sticky  = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// Bench for ccip_c0_rd_arbiter: vector table, hand-written corner sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_ccip_c0_rd_arbiter;

  localparam int N_REQ    = 4;
  localparam int ADDR_W   = 42;
  localparam int UMDATA_W = 12;
  localparam int MAX_OUT  = 32;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*ADDR_W-1:0]   req_addr;
  logic [N_REQ*UMDATA_W-1:0] req_mdata;
  logic [N_REQ-1:0]          req_ready;
  logic                      c0_tx_valid;
  logic [ADDR_W-1:0]         c0_tx_addr;
  logic [15:0]               c0_tx_mdata;
  logic                      c0_tx_almfull;
  logic                      c0_rx_valid;
  logic [15:0]               c0_rx_mdata;
  logic [511:0]              c0_rx_data;
  logic [N_REQ-1:0]          rsp_valid;
  logic [UMDATA_W-1:0]       rsp_mdata;
  logic [511:0]              rsp_data;
  logic                      drain_req;
  logic                      drained;
  logic                      err_sticky;
  logic [1:0]                dbg_state;

  ccip_c0_rd_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .UMDATA_W(UMDATA_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .pClk(clk), .pck_cp2af_softReset(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_mdata(req_mdata), .req_ready(req_ready),
    .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr), .c0_tx_mdata(c0_tx_mdata),
    .c0_tx_almfull(c0_tx_almfull),
    .c0_rx_valid(c0_rx_valid), .c0_rx_mdata(c0_rx_mdata), .c0_rx_data(c0_rx_data),
    .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
    .drain_req(drain_req), .drained(drained), .err_sticky(err_sticky), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W+16-1:0] exp_q[$];

  int                  m_ptr;
  int                  m_state;   // 0 run, 1 drain, 2 idle
  int                  m_cnt [N_REQ];
  logic                m_txv;
  logic [ADDR_W-1:0]   m_txa;
  logic [15:0]         m_txm;
  logic [N_REQ-1:0]    m_rspv;
  logic [UMDATA_W-1:0] m_rspm;
  logic [511:0]        m_rspd;
  logic                m_err;

  logic [ADDR_W-1:0]   a_addr [N_REQ];
  logic [UMDATA_W-1:0] a_md   [N_REQ];
  logic [N_REQ-1:0]    last_ready;

  typedef struct {
    logic [3:0] v;
    logic       af;
    logic [3:0] rdy;
    logic       txv;
    logic [3:0] id;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_state = 0; m_txv = 0; m_txa = '0; m_txm = '0;
    m_rspv = '0; m_rspm = '0; m_rspd = '0; m_err = 0;
    for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    req_valid = '0; c0_tx_almfull = 0; c0_rx_valid = 0; c0_rx_mdata = '0;
    c0_rx_data = '0; drain_req = 0;
  endtask

  // Called at posedge+1; asserts reset asynchronously and checks outputs clear before any edge.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_txv", c0_tx_valid, 0);
    chk("rst_txa", c0_tx_addr, 0);
    chk("rst_txm", c0_tx_mdata, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspm", rsp_mdata, 0);
    chk("rst_rspd", rsp_data, 0);
    chk("rst_drained", drained, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive, check combinational grant, advance model, check registered outputs.
  task automatic step();
    int g;
    int nstate;
    int id;
    logic all_zero;
    logic [N_REQ-1:0] exp_rdy;
    logic [ADDR_W+16-1:0] e;
    for (int i = 0; i < N_REQ; i++) begin
      a_addr[i] = ADDR_W'({$urandom(), $urandom()});
      a_md[i]   = UMDATA_W'($urandom());
      req_addr[i*ADDR_W +: ADDR_W]       = a_addr[i];
      req_mdata[i*UMDATA_W +: UMDATA_W] = a_md[i];
    end
    g = -1;
    if (m_state == 0 && !drain_req && !c0_tx_almfull)
      for (int k = 0; k < N_REQ; k++) begin
        int i;
        i = (m_ptr + k) % N_REQ;
        if (g < 0 && req_valid[i] && m_cnt[i] < MAX_OUT) g = i;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    #2;
    last_ready = req_ready;
    chk("ready", req_ready, exp_rdy);

    all_zero = 1;
    for (int i = 0; i < N_REQ; i++) if (m_cnt[i] != 0) all_zero = 0;
    nstate = m_state;
    case (m_state)
      0: if (drain_req) nstate = 1;
      1: if (!drain_req) nstate = 0; else if (all_zero && !m_txv) nstate = 2;
      default: if (!drain_req) nstate = 0;
    endcase

    m_rspv = '0;
    if (c0_rx_valid) begin
      id = int'(c0_rx_mdata[15:12]);
      if (id >= N_REQ) m_err = 1;
      else begin
        m_rspv[id] = 1'b1;
        m_rspm = c0_rx_mdata[UMDATA_W-1:0];
        m_rspd = c0_rx_data;
        if (m_cnt[id] == 0) m_err = 1;
        else m_cnt[id]--;
      end
    end

    if (g >= 0) begin
      m_cnt[g]++;
      m_ptr = (g + 1) % N_REQ;
      m_txv = 1;
      m_txa = a_addr[g];
      m_txm = {4'(g), 12'(a_md[g])};
      exp_q.push_back({m_txm, m_txa});
    end else m_txv = 0;
    m_state = nstate;

    @(posedge clk); #1;
    chk("tx_valid", c0_tx_valid, m_txv);
    chk("tx_addr", c0_tx_addr, m_txa);
    chk("tx_mdata", c0_tx_mdata, m_txm);
    if (c0_tx_valid) begin
      if (exp_q.size() == 0) chk("tx_unexpected", c0_tx_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("tx_sb", {c0_tx_mdata, c0_tx_addr}, e);
      end
    end
    chk("rsp_valid", rsp_valid, m_rspv);
    chk("rsp_mdata", rsp_mdata, m_rspm);
    chk("rsp_data", rsp_data, m_rspd);
    chk("err_sticky", err_sticky, m_err);
    chk("drained", drained, (m_state == 2));
    chk("state", dbg_state, m_state);
  endtask

  task automatic send_rsp(input logic [15:0] md);
    c0_rx_valid = 1'b1;
    c0_rx_mdata = md;
    for (int w = 0; w < 16; w++) c0_rx_data[w*32 +: 32] = $urandom();
    step();
    c0_rx_valid = 1'b0;
  endtask

  task automatic add(input logic [3:0] v, input logic af, input logic [3:0] rdy,
                     input logic txv, input logic [3:0] id);
    vec_t r;
    r.v = v; r.af = af; r.rdy = rdy; r.txv = txv; r.id = id;
    tbl.push_back(r);
  endtask

  initial begin
    idle_inputs();
    req_addr = '0; req_mdata = '0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Round-robin order, sparse requesters from pointer 2, almfull stall and resume.
    add(4'b1111, 0, 4'b0001, 1, 0); add(4'b1111, 0, 4'b0010, 1, 1);
    add(4'b1111, 0, 4'b0100, 1, 2); add(4'b1111, 0, 4'b1000, 1, 3);
    add(4'b1111, 0, 4'b0001, 1, 0); add(4'b1111, 0, 4'b0010, 1, 1);
    add(4'b1010, 0, 4'b1000, 1, 3); add(4'b1010, 0, 4'b0010, 1, 1);
    add(4'b1010, 0, 4'b1000, 1, 3);
    add(4'b1111, 0, 4'b0001, 1, 0);
    for (int i = 0; i < 5; i++) add(4'b1111, 1, 4'b0000, 0, 0);
    add(4'b1111, 0, 4'b0010, 1, 1);
    for (int t = 0; t < tbl.size(); t++) begin
      req_valid = tbl[t].v;
      c0_tx_almfull = tbl[t].af;
      step();
      chk("tbl_ready", last_ready, tbl[t].rdy);
      chk("tbl_txv", c0_tx_valid, tbl[t].txv);
      if (tbl[t].txv) chk("tbl_id", c0_tx_mdata[15:12], tbl[t].id);
    end

    // Outstanding limit on requester 0, then one response re-enables it.
    do_reset();
    req_valid = 4'b0001;
    for (int i = 0; i < MAX_OUT; i++) step();
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lim_blocked", last_ready[0], 0);
    end
    req_valid = '0;
    send_rsp(16'h0ABC);
    chk("lim_rspv", rsp_valid, 4'b0001);
    chk("lim_rspm", rsp_mdata, 12'hABC);
    req_valid = 4'b0001;
    step();
    chk("lim_reelig", last_ready, 4'b0001);

    // Bad ID, then underflow on a fresh counter.
    req_valid = '0;
    send_rsp(16'h5123);
    chk("badid_rspv", rsp_valid, 0);
    chk("badid_err", err_sticky, 1);
    do_reset();
    send_rsp(16'h2456);
    chk("uflow_err", err_sticky, 1);
    chk("uflow_rspv", rsp_valid, 4'b0100);
    drain_req = 1;
    step(); step();
    chk("uflow_cnt_zero", drained, 1);
    drain_req = 0;
    step();

    // Drain with three reads in flight.
    do_reset();
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) step();
    req_valid = 4'b1111;
    drain_req = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain_block", last_ready, 0);
    end
    send_rsp(16'h0001);
    send_rsp(16'h1002);
    send_rsp(16'h2003);
    chk("drain_not_yet", drained, 0);
    step();
    chk("drain_done", drained, 1);
    drain_req = 0;
    step();
    chk("idle_no_grant", last_ready, 0);
    step();
    chk("drain_resume", last_ready, 4'b1000);

    // Drain abandoned while reads are outstanding.
    drain_req = 1; step(); step();
    drain_req = 0; step();
    chk("abort_resume", dbg_state, 0);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int s;
      int id;
      req_valid = N_REQ'($urandom());
      c0_tx_almfull = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) drain_req = ~drain_req;
      c0_rx_valid = 0;
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, N_REQ - 1);
        id = -1;
        for (int k = 0; k < N_REQ; k++)
          if (id < 0 && m_cnt[(s + k) % N_REQ] > 0) id = (s + k) % N_REQ;
        if ($urandom_range(0, 29) == 0) id = $urandom_range(0, 15);
        if (id >= 0) begin
          c0_rx_valid = 1;
          c0_rx_mdata = {4'(id), 12'($urandom())};
          for (int w = 0; w < 16; w++) c0_rx_data[w*32 +: 32] = $urandom();
        end
      end
      step();
    end

    // Reset mid-operation, then a stale response counts as underflow.
    idle_inputs();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) step();
    do_reset();
    send_rsp(16'h1777);
    chk("stale_err", err_sticky, 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
